conv3x3_scheduler: RTL and testbench
====================================

Name: conv3x3_scheduler

Overview:
Sequencer for the 3x3 convolution engine (conv_3x3). It loads 9 weights from a weight stream, then accepts a raster-order feature map H x W from a pixel stream. It builds each 3x3 window using two line buffers and issues one engine transaction per valid-padding output position. It counts the engine's valid_out pulses and signals completion.

Parameters:
DATA_W, 16, width of pixel, weight and window taps (matches the engine).
MAX_W, 64, maximum row width; sets line buffer depth.
COL_W, 7, width of column and width-config fields (holds values up to MAX_W).
ROW_W, 10, width of row and height-config fields.
CNT_W, 16, width of the result counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
cfg_width  in  COL_W  image width W; legal range 3..MAX_W
cfg_height  in  ROW_W  image height H; legal minimum 3
busy  out  1  high in every state other than IDLE
done  out  1  one-cycle pulse at job completion
cfg_err  out  1  one-cycle pulse when start is given with an illegal config
w_valid  in  1  weight stream valid
w_data  in  DATA_W  weight value
w_ready  out  1  weight stream ready
pix_valid  in  1  pixel stream valid
pix_data  in  DATA_W  pixel value
pix_ready  out  1  pixel stream ready
conv_valid_in  out  1  drives engine valid_in
conv_win  out  9*DATA_W  tap k at [k*DATA_W +: DATA_W], drives data_in0..8
conv_wgt  out  9*DATA_W  weight k at [k*DATA_W +: DATA_W], drives weight0..8
conv_valid_out  in  1  engine valid_out
res_cnt  out  CNT_W  number of engine results received in the current job

Behaviour:
- Reset values: busy=0, done=0, cfg_err=0, w_ready=0, pix_ready=0, conv_valid_in=0, conv_win=0, conv_wgt=0, res_cnt=0, state=IDLE, all counters 0. Line buffer RAM contents are not reset.
- FSM states: IDLE, LOAD_W, RUN, DRAIN.
- IDLE:
  - start with a legal config: latch W and H, clear res_cnt, go to LOAD_W.
  - start with W<3, W>MAX_W or H<3: pulse cfg_err on the next cycle and stay in IDLE.
  - start while busy is ignored.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&&w_ready handshake writes weight[k], k=0..8. Weight 0 is top-left; order is raster.
  - On the 9th handshake, w_ready drops the next cycle and the FSM enters RUN.
  - conv_wgt is held stable from that point until the next LOAD_W.
- RUN:
  - pix_ready=1 until W*H pixels have been accepted.
  - On acceptance of pixel (r,c):
    - Window columns shift left.
    - New right column (top to bottom) = {lb1[c], lb0[c], pix}.
    - Then lb1[c] <= lb0[c] and lb0[c] <= pix.
  - If r>=2 and c>=2, conv_valid_in=1 for exactly the cycle after the accepting edge. conv_win then holds taps (r-2..r, c-2..c) in raster order, tap 8 = (r,c).
  - Otherwise conv_valid_in=0. conv_win holds its last value when not valid.
  - Column wrap: at c=W-1, c returns to 0 and r increments. Window contents crossing a row edge are never issued, because of the c>=2 gate.
  - pix_valid gaps: state, window and counters hold; no conv_valid_in is issued.
  - After the last pixel (r=H-1, c=W-1) is accepted, pix_ready drops the next cycle and the FSM enters DRAIN.
- DRAIN: wait until res_cnt == (W-2)*(H-2). Then pulse done for one cycle and go to IDLE. A start in that same cycle is ignored; the earliest accepted start is the following cycle.
- res_cnt increments on every conv_valid_out in RUN or DRAIN. Pulses seen in IDLE or LOAD_W are ignored.
- Engine latency is 3 cycles (valid_in to valid_out). The scheduler does not depend on it, only on the pulse count.
- Reset mid-job: immediately returns to the reset values. A new start is required; nothing from the partial job is retained except line buffer RAM, which is overwritten before use.

Decomposition:
- Shared package conv_pkg:
  - DATA_W, TAPS=9.
  - State encoding (IDLE=0, LOAD_W=1, RUN=2, DRAIN=3).
  - Function packing 9 taps into the 9*DATA_W bus.
- One sub-module, conv_window_gen:
  - Contains the two MAX_W-deep line buffers and the 3x3 window shift registers.
  - Inputs: shift enable, column index, pixel.
  - Output: 9 taps.
- The FSM, counters and weight registers stay in conv3x3_scheduler.

Test Plan:
1. Stream weights 1..9 with w_valid always high. Required: 9 handshakes, conv_wgt tap k = k+1, w_ready low the cycle after the 9th handshake, state RUN.
2. 4x4 image, pixels 0..15, no gaps; behavioural engine model with 3-cycle latency. Required:
   - exactly 4 conv_valid_in pulses;
   - windows {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15};
   - res_cnt=4, one done pulse, busy=0 afterwards.
3. Same 4x4 image with pix_valid high every other cycle. Required: identical 4 windows, each pulse exactly one cycle after an accepting edge, done once.
4. start with cfg_width=2, then cfg_height=2, then cfg_width=65. Required: a cfg_err pulse each time, busy stays 0, w_ready stays 0.
5. Assert rst_n low after 7 pixels of a 4x4 job, then start a 3x3 job (weights 1..9, pixels 0..8). Required: all outputs at reset values during reset; exactly one window {0..8}; done with res_cnt=1.
6. 64x3 image (W=MAX_W), pixels = column index. Required: 62 conv_valid_in pulses; the first window's rows are each {0,1,2}; no window mixes columns 63 and 0; res_cnt=62 at done.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, FSM encoding and tap packing for the 3x3 convolution scheduler
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Tap k lands at [k*DATA_W +: DATA_W]; tap 0 is the top-left of the window.
  function automatic logic [TAPS*DATA_W-1:0] pack_taps(input logic [DATA_W-1:0] taps [TAPS]);
    logic [TAPS*DATA_W-1:0] bus;
    for (int k = 0; k < TAPS; k++) begin
      bus[k*DATA_W +: DATA_W] = taps[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - two line buffers plus a 3x3 window whose right column is the current pixel
module conv_window_gen
  import conv_pkg::TAPS, conv_pkg::pack_taps;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 64,
  parameter int AW     = $clog2(MAX_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift,
  input  logic [AW-1:0]          col,
  input  logic [DATA_W-1:0]      pix,
  output logic [TAPS*DATA_W-1:0] taps
);

  logic [DATA_W-1:0] lb0 [MAX_W];
  logic [DATA_W-1:0] lb1 [MAX_W];
  logic [DATA_W-1:0] left  [3];
  logic [DATA_W-1:0] mid   [3];
  logic [DATA_W-1:0] right [3];
  logic [DATA_W-1:0] win   [TAPS];

  // The newest column is read straight from the line buffers so the window is complete
  // in the same cycle the pixel is accepted.
  assign right[0] = lb1[col];
  assign right[1] = lb0[col];
  assign right[2] = pix;

  always_ff @(posedge clk) begin
    if (shift) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left <= '{default: '0};
      mid  <= '{default: '0};
    end else if (shift) begin
      left <= mid;
      mid  <= right;
    end
  end

  always_comb begin
    win = '{default: '0};
    for (int r = 0; r < 3; r++) begin
      win[3*r]     = left[r];
      win[3*r + 1] = mid[r];
      win[3*r + 2] = right[r];
    end
  end

  assign taps = pack_taps(win);

endmodule

// File: rtl/conv3x3_scheduler.sv
// rtl/conv3x3_scheduler.sv - loads 9 weights, streams a raster image, issues one engine job per 3x3 window
module conv3x3_scheduler
  import conv_pkg::TAPS, conv_pkg::state_t, conv_pkg::pack_taps,
         conv_pkg::IDLE, conv_pkg::LOAD_W, conv_pkg::RUN, conv_pkg::DRAIN;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 64,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COL_W-1:0]       cfg_width,
  input  logic [ROW_W-1:0]       cfg_height,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  input  logic                   w_valid,
  input  logic [DATA_W-1:0]      w_data,
  output logic                   w_ready,
  input  logic                   pix_valid,
  input  logic [DATA_W-1:0]      pix_data,
  output logic                   pix_ready,
  output logic                   conv_valid_in,
  output logic [TAPS*DATA_W-1:0] conv_win,
  output logic [TAPS*DATA_W-1:0] conv_wgt,
  input  logic                   conv_valid_out,
  output logic [CNT_W-1:0]       res_cnt
);

  localparam int AW = $clog2(MAX_W);

  state_t                   state, next_state;
  logic [COL_W-1:0]         width, col;
  logic [ROW_W-1:0]         height, row;
  logic [3:0]               w_idx;
  logic [DATA_W-1:0]        wgt [TAPS];
  logic [TAPS*DATA_W-1:0]   taps;
  logic [COL_W+ROW_W-1:0]   n_out;
  logic                     cfg_ok, w_fire, pix_fire, last_pix;

  assign cfg_ok   = (cfg_width >= COL_W'(3)) && (cfg_width <= COL_W'(MAX_W)) &&
                    (cfg_height >= ROW_W'(3));
  assign w_fire   = w_ready && w_valid;
  assign pix_fire = pix_ready && pix_valid;
  assign last_pix = (row == height - ROW_W'(1)) && (col == width - COL_W'(1));
  assign n_out    = {{ROW_W{1'b0}}, width - COL_W'(2)} * {{COL_W{1'b0}}, height - ROW_W'(2)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    w_ready    = 1'b0;
    pix_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && cfg_ok) next_state = LOAD_W;
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && w_idx == 4'd8) next_state = RUN;
      end
      RUN: begin
        pix_ready = 1'b1;
        if (pix_valid && last_pix) next_state = DRAIN;
      end
      DRAIN: begin
        if (res_cnt == CNT_W'(n_out)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width         <= '0;
      height        <= '0;
      col           <= '0;
      row           <= '0;
      w_idx         <= '0;
      wgt           <= '{default: '0};
      cfg_err       <= 1'b0;
      conv_valid_in <= 1'b0;
      conv_win      <= '0;
      res_cnt       <= '0;
    end else begin
      cfg_err       <= (state == IDLE) && start && !cfg_ok;
      conv_valid_in <= 1'b0;
      if (state == IDLE && start && cfg_ok) begin
        width   <= cfg_width;
        height  <= cfg_height;
        col     <= '0;
        row     <= '0;
        w_idx   <= '0;
        res_cnt <= '0;
      end
      if (w_fire) begin
        wgt[w_idx] <= w_data;
        w_idx      <= (w_idx == 4'd8) ? 4'd0 : w_idx + 4'd1;
      end
      // Windows touching columns 0/1 would straddle the previous row, so they are never issued.
      if (pix_fire) begin
        if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
          conv_valid_in <= 1'b1;
          conv_win      <= taps;
        end
        if (col == width - COL_W'(1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if ((state == RUN || state == DRAIN) && conv_valid_out) res_cnt <= res_cnt + CNT_W'(1);
    end
  end

  assign conv_wgt = pack_taps(wgt);

  conv_window_gen #(
    .DATA_W (DATA_W),
    .MAX_W  (MAX_W),
    .AW     (AW)
  ) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (pix_fire),
    .col   (col[AW-1:0]),
    .pix   (pix_data),
    .taps  (taps)
  );

endmodule

// File: tb/tb_conv3x3_scheduler.sv
// tb/tb_conv3x3_scheduler.sv - directed bench for conv3x3_scheduler with a 3-cycle engine model
module tb_conv3x3_scheduler;

  localparam int DATA_W = 16;
  localparam int MAX_W  = 64;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 10;
  localparam int CNT_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [COL_W-1:0]     cfg_width = '0;
  logic [ROW_W-1:0]     cfg_height = '0;
  logic                 busy, done, cfg_err;
  logic                 w_valid = 1'b0;
  logic [DATA_W-1:0]    w_data = '0;
  logic                 w_ready;
  logic                 pix_valid = 1'b0;
  logic [DATA_W-1:0]    pix_data = '0;
  logic                 pix_ready;
  logic                 conv_valid_in;
  logic [9*DATA_W-1:0]  conv_win, conv_wgt;
  logic                 conv_valid_out;
  logic [CNT_W-1:0]     res_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int job_w = 4;
  int job_mode = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;
  logic acc_q = 1'b0;
  logic [2:0] pipe;

  always #5 clk = ~clk;

  conv3x3_scheduler #(
    .DATA_W (DATA_W), .MAX_W (MAX_W), .COL_W (COL_W), .ROW_W (ROW_W), .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .w_valid        (w_valid),
    .w_data         (w_data),
    .w_ready        (w_ready),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .conv_valid_in  (conv_valid_in),
    .conv_win       (conv_win),
    .conv_wgt       (conv_wgt),
    .conv_valid_out (conv_valid_out),
    .res_cnt        (res_cnt)
  );

  // Engine stand-in: valid_out follows valid_in three cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[1:0], conv_valid_in};
  end
  assign conv_valid_out = pipe[2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel value at image position: raster index, or column index in column mode.
  function automatic int exp_tap(input int p, input int k);
    int r, c;
    r = p / (job_w - 2) + k / 3;
    c = p % (job_w - 2) + k % 3;
    return (job_mode != 0) ? c : r * job_w + c;
  endfunction

  always @(posedge clk) acc_q <= pix_valid && pix_ready;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (conv_valid_in) begin
      chk("pulse_after_accept", int'(acc_q), 1);
      for (int k = 0; k < 9; k++)
        chk("win_tap", int'(conv_win[k*DATA_W +: DATA_W]), exp_tap(pulse_cnt, k));
      pulse_cnt++;
    end
  end

  task automatic start_job(input int w, input int h);
    cfg_width  = COL_W'(w);
    cfg_height = ROW_W'(h);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    job_w      = w;
    pulse_cnt  = 0;
    done_cnt   = 0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic load_weights();
    int k, guard;
    logic hs;
    k = 0;
    guard = 0;
    w_valid = 1'b1;
    w_data  = DATA_W'(1);
    while (k < 9 && guard < 40) begin
      hs = w_ready;
      @(negedge clk);
      guard++;
      if (hs) begin
        k++;
        w_data = DATA_W'(k + 1);
      end
    end
    w_valid = 1'b0;
    chk("w_handshakes", k, 9);
    chk("w_ready_drop", int'(w_ready), 0);
    chk("run_entered", int'(pix_ready), 1);
    for (int i = 0; i < 9; i++)
      chk("wgt_tap", int'(conv_wgt[i*DATA_W +: DATA_W]), i + 1);
  endtask

  task automatic send_pixels(input int w, input int h, input bit gap, input int limit);
    int n, cyc;
    logic hs;
    n = 0;
    cyc = 0;
    while (n < limit && cyc < 2000) begin
      pix_valid = !gap || (cyc % 2 == 0);
      pix_data  = DATA_W'((job_mode != 0) ? n % w : n);
      hs = pix_valid && pix_ready;
      @(negedge clk);
      cyc++;
      if (hs) n++;
    end
    pix_valid = 1'b0;
    chk("pix_accepted", n, limit);
    if (limit == w * h) chk("pix_ready_drop", int'(pix_ready), 0);
  endtask

  task automatic wait_done(input int exp_res);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      if (done) begin
        seen = 1'b1;
        chk("res_cnt_at_done", int'(res_cnt), exp_res);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", int'(seen), 1);
    repeat (4) @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_once", done_cnt, 1);
    chk("pulse_count", pulse_cnt, exp_res);
    chk("res_cnt_hold", int'(res_cnt), exp_res);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_w_ready", int'(w_ready), 0);
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_valid_in", int'(conv_valid_in), 0);
    chk("rst_win", int'(|conv_win), 0);
    chk("rst_wgt", int'(|conv_wgt), 0);
    chk("rst_res_cnt", int'(res_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Weight load then a gap-free 4x4 image
    job_mode = 0;
    start_job(4, 4);
    load_weights();
    send_pixels(4, 4, 1'b0, 16);
    wait_done(4);

    // Same image, pixel stream valid every other cycle
    start_job(4, 4);
    load_weights();
    send_pixels(4, 4, 1'b1, 16);
    wait_done(4);

    // Illegal configurations
    for (int i = 0; i < 3; i++) begin
      cfg_width  = (i == 0) ? COL_W'(2) : (i == 1) ? COL_W'(4) : COL_W'(65);
      cfg_height = (i == 1) ? ROW_W'(2) : ROW_W'(4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      chk("cfg_busy", int'(busy), 0);
      chk("cfg_w_ready", int'(w_ready), 0);
      @(negedge clk);
      chk("cfg_err_clear", int'(cfg_err), 0);
      chk("cfg_busy_after", int'(busy), 0);
    end

    // Reset in the middle of a job, then a fresh 3x3 job
    start_job(4, 4);
    load_weights();
    send_pixels(4, 4, 1'b0, 7);
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(3, 3);
    load_weights();
    send_pixels(3, 3, 1'b0, 9);
    wait_done(1);

    // Full-width image, pixel value = column index
    job_mode = 1;
    start_job(64, 3);
    load_weights();
    send_pixels(64, 3, 1'b0, 192);
    wait_done(62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
